// File: rtl/hc595_chain_driver.sv
// hc595_chain_driver
//   Serial driver for a chain of CHAIN cascaded 74HC595 shift registers.
//   Whole frames of W = 8*CHAIN bits arrive over valid/ready. One frame is
//   buffered ahead so refreshes run back to back with no idle gap.
//
// Ports
//   sysclk      system clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   in_valid    frame offered
//   in_data     frame contents [W-1:0]
//   in_ready    frame can be accepted (pending buffer empty)
//   blank       force the 595 outputs off
//   busy        high while shifting or latching
//   frame_done  one-cycle pulse after each latch
//   sck         595 SH_CP
//   latch       595 ST_CP
//   sdata       595 DS
//   oe_n        595 OE, active low; dark until the first frame is latched
module hc595_chain_driver #(
  parameter int DIV       = 10,
  parameter int CHAIN     = 2,
  parameter int LSB_FIRST = 0,
  parameter int LATCH_W   = 2
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [8*CHAIN-1:0] in_data,
  output logic               in_ready,
  input  logic               blank,
  output logic               busy,
  output logic               frame_done,
  output logic               sck,
  output logic               latch,
  output logic               sdata,
  output logic               oe_n
);

  localparam int W  = 8 * CHAIN;
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(W + 1);
  localparam int LW = $clog2(LATCH_W + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [W-1:0]    pend;
  logic            pend_full;
  logic            shown;
  logic            last_bit;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [LW-1:0]   latch_cnt;

  logic xfer, latch_end, direct, out_bit;

  assign in_ready  = ~pend_full;
  assign xfer      = in_valid & in_ready;
  assign latch_end = (state == LATCH) && (latch_cnt == LAT_LAST);
  // Straight into sreg only when nothing is queued ahead of it
  // (xfer already implies pend is empty).
  assign direct    = xfer && ((state == IDLE) || latch_end);

  assign out_bit   = (LSB_FIRST != 0) ? sreg[0] : sreg[W-1];

  // Pin outputs are decoded straight from state registers so the first bit
  // appears in the same cycle the frame is loaded.
  assign busy  = (state != IDLE);
  assign sck   = (state == SHIFT) && (div_cnt >= DIV_HALF);
  assign latch = (state == LATCH);
  // sreg has already shifted past the final bit by LATCH, so hold a copy.
  assign sdata = (state == SHIFT) ? out_bit :
                 (state == LATCH) ? last_bit : 1'b0;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      shown      <= 1'b0;
      last_bit   <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      latch_cnt  <= '0;
      frame_done <= 1'b0;
      oe_n       <= 1'b1;
    end else begin
      frame_done <= latch_end;
      if (latch_end) shown <= 1'b1;
      // Uses shown before this edge, so oe_n drops the cycle after frame_done.
      oe_n <= blank | ~shown;

      if (xfer && !direct) begin
        pend      <= in_data;
        pend_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (direct) begin
            sreg    <= in_data;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            last_bit <= out_bit;
            if (LSB_FIRST != 0) sreg <= sreg >> 1;
            else                sreg <= sreg << 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt   <= '0;
              latch_cnt <= '0;
              state     <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (latch_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            if (pend_full) begin
              // No xfer can coincide here: in_ready is low while pend is full.
              sreg      <= pend;
              pend_full <= 1'b0;
              state     <= SHIFT;
            end else if (direct) begin
              sreg  <= in_data;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hc595_chain_driver.md
# hc595_chain_driver

Parametrised serial driver for a chain of cascaded 74HC595 shift registers. It feeds the digit-select and segment registers of the digital-tube display and any other 595-based output expander. It accepts whole frames of 8·CHAIN bits over a valid/ready handshake and buffers one frame ahead, so refreshes run back to back. It generates sck, sdata, latch and a blanking output-enable, with selectable bit order.

## Interface
- DIV, 10: sysclk cycles per sck period; even, ≥ 4.
- CHAIN, 2: number of cascaded 595s. Frame width W = 8·CHAIN.
- LSB_FIRST, 0: 0 = frame bit W-1 shifted first; 1 = bit 0 shifted first.
- LATCH_W, 2: latch high time in sysclk cycles; ≥ 1.

Ports:
- sysclk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a frame is offered.
- in_data  in  W  frame contents.
- in_ready  out  1  frame can be accepted; transfer = in_valid & in_ready at a rising edge.
- blank  in  1  force the 595 outputs off.
- busy  out  1  high in SHIFT or LATCH.
- frame_done  out  1  one-cycle pulse after each latch.
- sck  out  1  595 SH_CP.
- latch  out  1  595 ST_CP.
- sdata  out  1  595 DS.
- oe_n  out  1  595 OE, active low.

## Operation
- State machine has three states: IDLE, SHIFT and LATCH.
- **Registers:** shift register sreg[W], pending buffer pend[W] with flag pend_full, div_cnt (0..DIV-1), bit_cnt (0..W-1), latch_cnt (0..LATCH_W-1), and a shown flag.
- **in_ready** = ~pend_full.
- **Direct load.** A transfer goes straight into sreg, with div_cnt = 0 and bit_cnt = 0, when both hold:
  - pend_full = 0; and
  - the state is IDLE, or this is the final LATCH cycle.
  - Next state is SHIFT.
- **Buffered transfer.** Any other transfer is written to pend and sets pend_full.
- **LATCH exit.** On the final LATCH cycle:
  - if pend_full, pend moves to sreg, pend_full clears and the state goes to SHIFT;
  - otherwise the state goes to IDLE, unless a direct load applies.
- **SHIFT:**
  - div_cnt increments and wraps at DIV-1.
  - sck = 1 exactly when div_cnt ≥ DIV/2.
  - sdata = sreg[W-1] (MSB-first) or sreg[0] (LSB-first).
  - At div_cnt = DIV-1, sreg shifts by one (left or right, zero fill) and bit_cnt increments.
  - At div_cnt = DIV-1 with bit_cnt = W-1, the state goes to LATCH with latch_cnt = 0.
- **LATCH:**
  - latch = 1, sck = 0.
  - sdata holds the last bit.
  - Lasts LATCH_W cycles.
- **IDLE:** sck = 0, latch = 0, sdata = 0.
- **frame_done** is registered. It is high for the single cycle after the final LATCH cycle.
- **shown** sets at the first frame_done after reset.
- **oe_n** is registered: oe_n = blank | ~shown. The display therefore stays dark until the first complete frame has been latched.

## Timing
- **Reset values:** state IDLE; sck = 0, latch = 0, sdata = 0, frame_done = 0, busy = 0, in_ready = 1, oe_n = 1; pend_full = 0, shown = 0.
- **Reset mid-operation:** rst aborts any frame at the next edge with no latch pulse. Pending data is discarded. A transfer presented in the same cycle as rst is ignored.
- **Handshake to first bit:**
  - Transfer at edge T from IDLE gives busy = 1 and the first bit on sdata from T.
  - First sck rise at T + DIV/2.
  - Data setup before each sck rise = DIV/2 cycles; hold after = DIV/2 cycles.
- **Frame length:** SHIFT lasts W·DIV cycles; latch rises at T + W·DIV and stays high LATCH_W cycles.
- **frame_done** is high at T + W·DIV + LATCH_W.
- **Back to back:** a pending or direct-loaded frame starts SHIFT on the cycle after the last LATCH cycle, with zero idle gap. Frame period = W·DIV + LATCH_W.
- **Full buffer:** with pend_full = 1, in_ready = 0; the offered frame must be held by the source.
- **Simultaneous events:**
  - A transfer on the final LATCH cycle with pend empty is a direct load.
  - A transfer on the final LATCH cycle with pend full is impossible, because in_ready = 0.
- **oe_n** follows blank with 1 cycle latency.

## Test plan
- **MSB-first frame.** DIV = 10, CHAIN = 2, LSB_FIRST = 0; send 0x0F65 from idle.
  - Required: bits sampled on sck rises = 0000_1111_0110_0101.
  - Required: latch high cycles T+160..T+161; frame_done at T+162; oe_n falls at T+163.
- **LSB-first frame.** Same setup with LSB_FIRST = 1, send 0x0F65.
  - Required: sampled bits = 1010_0110_1111_0000.
- **Back-to-back frames.** Send 0x1234, then 0xABCD at T+5, then 0x5555 at T+6.
  - Required: in_ready = 0 from T+6, so 0x5555 is stalled.
  - Required: 0xABCD SHIFT starts at T+162, with no gap after the latch.
  - Required: 0x5555 is accepted at T+162 and starts at T+324.
- **Direct load on final LATCH cycle.** Offer 0x00FF exactly on the final LATCH cycle with pend empty.
  - Required: next cycle is SHIFT with first bit 0 (MSB-first); no IDLE cycle in between.
- **Reset mid-shift.** Assert rst after 7 sck rises, with pend holding 0xAAAA.
  - Required: next cycle all outputs at reset values; no latch pulse; oe_n = 1.
  - Required: 0xAAAA is never shifted; a later frame 0x8001 shifts correctly.
- **Blanking.** After the first frame, toggle blank 0 → 1 → 0.
  - Required: oe_n = 1 one cycle after blank rises and 0 one cycle after it falls.
  - Required: shifting and latch are unaffected.
